esdi_cmd_initiator: RTL and testbench
=====================================

ESDI_CMD_INITIATOR -- requirements
Module: esdi_cmd_initiator

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 6, clocks COMMAND DATA is held stable before TRANSFER REQ rises.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4000, maximum clocks spent in any wait state.
REQ-003 SHALL have ports: csr_aclk in 1, sole clock; csr_aresetn in 1, reset, asynchronous active-low.
REQ-004 SHALL have ports: cmd_valid in 1, cmd_ready out 1, cmd_word in 16, cmd_resp_words in 3 (config/status words to read back, 0-7).
REQ-005 SHALL have ports: resp_valid out 1 (one-cycle pulse), resp_word out 16, resp_parity_err out 1 (qualified by resp_valid).
REQ-006 SHALL have ports: done out 1 (one-cycle pulse), timeout out 1 (one-cycle pulse, qualified by done), busy out 1.
REQ-007 SHALL have ports: esdi_transfer_req out 1, esdi_command_data out 1, esdi_transfer_ack in 1, esdi_confstat_data in 1, esdi_command_complete in 1.

Function
REQ-008 SHALL pass esdi_transfer_ack, esdi_confstat_data and esdi_command_complete through 2-flop synchronizers; all decisions use the synchronized values.
REQ-009 SHALL assert cmd_ready only in IDLE; accept on cmd_valid && cmd_ready, capturing cmd_word, cmd_resp_words, and parity bit = XNOR-reduce of cmd_word (odd parity over 17 bits).
REQ-010 SHALL use states IDLE, TX_SETUP, TX_REQ, TX_REL, RX_REQ, RX_REL, WAIT_CC, FINISH.
REQ-011 SHALL transmit 17 bits MSB first (cmd_word[15] first, parity last); per bit: TX_SETUP drives esdi_command_data for SETUP_CYCLES clocks with req low.
REQ-012 SHALL in TX_REQ hold req high until synchronized ack is high, then go to TX_REL, drop req, and wait for ack low.
REQ-013 SHALL after ack low in TX_REL advance to the next bit, or after bit 17 go to RX_REQ if resp count nonzero, else WAIT_CC.
REQ-014 SHALL in RX_REQ raise req and, on the first clock synchronized ack is high, shift in synchronized confstat_data, MSB first, then drop req in RX_REL and wait for ack low.
REQ-015 SHALL after the 17th bit of a response word pulse resp_valid for one clock with resp_word = first 16 bits; decrement remaining count; repeat RX_REQ or go to WAIT_CC.
REQ-016 SHALL in WAIT_CC wait for synchronized command_complete high, then FINISH pulses done with timeout=0 and returns to IDLE.
REQ-017 SHALL on any wait state (TX_REQ, TX_REL, RX_REQ, RX_REL, WAIT_CC) exceeding TIMEOUT_CYCLES drop req, pulse done with timeout=1, return to IDLE; timeout counter clears on every state change.
REQ-018 SHALL ignore ack changes outside wait states; ack already high on entry to TX_REQ/RX_REQ is treated as acknowledge.
REQ-019 SHALL drive busy = (state != IDLE); esdi_command_data SHALL be 0 outside TX states.

Reset
REQ-020 SHALL on csr_aresetn low, at any time including mid-transfer, force IDLE, req=0, command_data=0, resp_valid=0, done=0, timeout=0, resp_parity_err=0, counters and synchronizers 0; cmd_ready=1 on first clock after release.

Configuration
REQ-021 SHALL with ESDI_INIT_PARITY_CHECK_EN defined set resp_parity_err=1 when the 17 received bits have even parity.
REQ-022 SHALL without ESDI_INIT_PARITY_CHECK_EN tie resp_parity_err to 0 and omit check logic; the 17th bit is still clocked in.

Structure
REQ-023 SHALL place the state enumeration, ESDI_WORD_BITS=17 and the odd-parity function in shared package esdi_pkg.
REQ-024 SHALL instantiate sub-module esdi_sync2 (2-flop synchronizer) once per drive input.

Verification
REQ-025 SHALL cover: cmd_word=0x000E, resp 0, drive model acks each req after 3 clocks -> 17 bits 0,...,1,1,1,0 seen, parity bit 0, done, timeout=0.
REQ-026 SHALL cover: cmd_word=0x0001 -> parity bit 0 transmitted; cmd_word=0x0000 -> parity bit 1.
REQ-027 SHALL cover: resp 2, drive returns 0xA5A5+parity 1 and 0x1234+parity 0 -> two resp_valid pulses, words 0xA5A5,0x1234, resp_parity_err 0,0 (with macro).
REQ-028 SHALL cover: drive never acks bit 5 -> req low and done with timeout=1 after TIMEOUT_CYCLES; cmd_ready high next clock.
REQ-029 SHALL cover: reset asserted during RX of word 1 -> req and all pulses 0 immediately; new command afterwards completes normally.
REQ-030 SHALL cover: with macro, drive returns 0x0003+parity 0 -> resp_parity_err=1; without macro, same stimulus -> 0.

Source files
------------

// File: rtl/esdi_pkg.sv
// Shared definitions for the ESDI command initiator: FSM states, serial word
// length and the odd-parity helper used when framing outgoing commands.
package esdi_pkg;

  localparam int ESDI_WORD_BITS = 17;

  typedef enum logic [2:0] {
    IDLE,
    TX_SETUP,
    TX_REQ,
    TX_REL,
    RX_REQ,
    RX_REL,
    WAIT_CC,
    FINISH
  } esdi_state_t;

  // Bit that makes {w, bit} contain an odd number of ones.
  function automatic logic odd_parity(input logic [15:0] w);
    return ~^w;
  endfunction

endpackage

// File: rtl/esdi_sync2.sv
// Two-flop synchronizer for one asynchronous ESDI drive line.
module esdi_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ff_q <= 2'b00;
    else         ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/esdi_cmd_initiator.sv
// ESDI serial command initiator: shifts a 16-bit command plus odd parity to the
// drive, reads back config/status words, then waits for command complete.
// Optional response parity checking is enabled with ESDI_INIT_PARITY_CHECK_EN.
module esdi_cmd_initiator
  import esdi_pkg::*;
#(
  parameter int SETUP_CYCLES   = 6,
  parameter int TIMEOUT_CYCLES = 4000
) (
  input  logic        csr_aclk,
  input  logic        csr_aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_word,
  input  logic [2:0]  cmd_resp_words,
  output logic        resp_valid,
  output logic [15:0] resp_word,
  output logic        resp_parity_err,
  output logic        done,
  output logic        timeout,
  output logic        busy,
  output logic        esdi_transfer_req,
  output logic        esdi_command_data,
  input  logic        esdi_transfer_ack,
  input  logic        esdi_confstat_data,
  input  logic        esdi_command_complete
);

  localparam int CW         = $clog2(TIMEOUT_CYCLES + SETUP_CYCLES + 2);
  localparam int BW         = $clog2(ESDI_WORD_BITS);
  localparam int SETUP_LAST = (SETUP_CYCLES > 1) ? SETUP_CYCLES - 1 : 0;

  logic ack_s, conf_s, cc_s;

  esdi_sync2 u_sync_ack  (.clk_i(csr_aclk), .rst_ni(csr_aresetn), .d_i(esdi_transfer_ack),     .q_o(ack_s));
  esdi_sync2 u_sync_conf (.clk_i(csr_aclk), .rst_ni(csr_aresetn), .d_i(esdi_confstat_data),    .q_o(conf_s));
  esdi_sync2 u_sync_cc   (.clk_i(csr_aclk), .rst_ni(csr_aresetn), .d_i(esdi_command_complete), .q_o(cc_s));

  esdi_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [16:0]   tx_q, tx_d, rx_q, rx_d;
  logic [2:0]    rcnt_q, rcnt_d;
  logic          to_q, to_d;
  logic          resp_valid_q, resp_valid_d;
  logic [15:0]   resp_word_q, resp_word_d;
  logic          expired, last_bit;

  assign expired  = (cnt_q == CW'(TIMEOUT_CYCLES));
  assign last_bit = (bit_q == BW'(ESDI_WORD_BITS - 1));

  always_comb begin
    state_d      = state_q;
    bit_d        = bit_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    rcnt_d       = rcnt_q;
    to_d         = to_q;
    resp_valid_d = 1'b0;
    resp_word_d  = resp_word_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          tx_d    = {cmd_word, odd_parity(cmd_word)};
          rcnt_d  = cmd_resp_words;
          bit_d   = '0;
          to_d    = 1'b0;
          state_d = TX_SETUP;
        end
      end
      TX_SETUP: begin
        if (cnt_q >= CW'(SETUP_LAST)) state_d = TX_REQ;
      end
      TX_REQ: begin
        if (ack_s)        state_d = TX_REL;
        else if (expired) begin state_d = FINISH; to_d = 1'b1; end
      end
      TX_REL: begin
        if (!ack_s) begin
          if (last_bit) begin
            bit_d   = '0;
            state_d = (rcnt_q != 3'd0) ? RX_REQ : WAIT_CC;
          end else begin
            bit_d   = bit_q + BW'(1);
            tx_d    = {tx_q[15:0], 1'b0};
            state_d = TX_SETUP;
          end
        end else if (expired) begin
          state_d = FINISH;
          to_d    = 1'b1;
        end
      end
      RX_REQ: begin
        if (ack_s) begin
          rx_d    = {rx_q[15:0], conf_s};
          state_d = RX_REL;
        end else if (expired) begin
          state_d = FINISH;
          to_d    = 1'b1;
        end
      end
      RX_REL: begin
        // The 17th (parity) bit is already in rx_q once its ack drops.
        if (!ack_s) begin
          if (last_bit) begin
            resp_valid_d = 1'b1;
            resp_word_d  = rx_q[16:1];
            rcnt_d       = rcnt_q - 3'd1;
            bit_d        = '0;
            state_d      = (rcnt_q > 3'd1) ? RX_REQ : WAIT_CC;
          end else begin
            bit_d   = bit_q + BW'(1);
            state_d = RX_REQ;
          end
        end else if (expired) begin
          state_d = FINISH;
          to_d    = 1'b1;
        end
      end
      WAIT_CC: begin
        if (cc_s)         state_d = FINISH;
        else if (expired) begin state_d = FINISH; to_d = 1'b1; end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      rcnt_q       <= '0;
      to_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_word_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      rcnt_q       <= rcnt_d;
      to_q         <= to_d;
      resp_valid_q <= resp_valid_d;
      resp_word_q  <= resp_word_d;
    end
  end

`ifdef ESDI_INIT_PARITY_CHECK_EN
  // Flags a received word whose 17 bits carry an even number of ones.
  logic perr_q;
  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) perr_q <= 1'b0;
    else              perr_q <= resp_valid_d & ~(^rx_q);
  end
  assign resp_parity_err = perr_q;
`else
  assign resp_parity_err = 1'b0;
`endif

  assign cmd_ready         = (state_q == IDLE);
  assign busy              = (state_q != IDLE);
  assign esdi_transfer_req = (state_q == TX_REQ) || (state_q == RX_REQ);
  assign esdi_command_data = (state_q inside {TX_SETUP, TX_REQ, TX_REL}) & tx_q[16];
  assign done              = (state_q == FINISH);
  assign timeout           = (state_q == FINISH) & to_q;
  assign resp_valid        = resp_valid_q;
  assign resp_word         = resp_word_q;

endmodule

// File: tb/tb_esdi_cmd_initiator.sv
// Directed bench for esdi_cmd_initiator with a behavioural drive model and
// queue-based scoreboard for transmitted bits, response words and completion.
module tb_esdi_cmd_initiator;

  localparam int SETUP = 6;
  localparam int TO    = 200;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_word = '0;
  logic [2:0]  cmd_resp_words = '0;
  logic        resp_valid;
  logic [15:0] resp_word;
  logic        resp_parity_err;
  logic        done, timeout, busy;
  logic        req, cdata;
  logic        ack = 1'b0, conf = 1'b0, cc = 1'b0;

  int checks = 0;
  int errors = 0;

  logic        exp_tx[$];
  logic [16:0] exp_resp[$];
  logic        exp_to[$];
  logic        rx_bits[$];

  int hs = 0;
  int stall_hs = -1;
  int total_hs = 0;
  int done_cnt = 0;
  int cyc = 0;
  int done_cyc = 0;
  int stall_cyc = 0;
  logic [16:0] e_resp;
  logic        e_bit;

  always #5 clk = ~clk;

  esdi_cmd_initiator #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TO)) dut (
    .csr_aclk(clk), .csr_aresetn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_word(cmd_word),
    .cmd_resp_words(cmd_resp_words),
    .resp_valid(resp_valid), .resp_word(resp_word), .resp_parity_err(resp_parity_err),
    .done(done), .timeout(timeout), .busy(busy),
    .esdi_transfer_req(req), .esdi_command_data(cdata),
    .esdi_transfer_ack(ack), .esdi_confstat_data(conf), .esdi_command_complete(cc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive model: acks each request 3 clocks after seeing it, presents the
  // response bit one clock before the ack, releases ack once req drops.
  always begin : drive_model
    int n;
    @(posedge clk); #1;
    if (rstn && req) begin
      if (hs == stall_hs) begin
        stall_cyc = cyc;
        n = 0;
        while (req && n < 3 * TO) begin @(posedge clk); #1; n++; end
      end else begin
        if (hs < 17) begin
          if (exp_tx.size() == 0) chk("tx_extra_bit", 1, 0);
          else begin
            e_bit = exp_tx.pop_front();
            chk("tx_bit", cdata, e_bit);
          end
        end
        repeat (2) begin @(posedge clk); #1; end
        if (hs >= 17) conf = (rx_bits.size() != 0) ? rx_bits.pop_front() : 1'b0;
        @(posedge clk); #1;
        ack = 1'b1;
        n = 0;
        while (req && n < 3 * TO) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        ack = 1'b0;
        hs++;
        if (hs == total_hs) begin @(posedge clk); #1; cc = 1'b1; end
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (resp_valid) begin
      if (exp_resp.size() == 0) chk("resp_extra", 1, 0);
      else begin
        e_resp = exp_resp.pop_front();
        chk("resp_word", {16'h0, resp_word}, {16'h0, e_resp[16:1]});
        chk("resp_parity_err", resp_parity_err, e_resp[0]);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (exp_to.size() == 0) chk("done_extra", 1, 0);
      else begin
        e_bit = exp_to.pop_front();
        chk("timeout_flag", timeout, e_bit);
      end
      chk("req_low_at_done", req, 0);
    end
  end

  task automatic add_resp(input logic [15:0] w, input logic p);
    logic [16:0] b;
    logic perr;
    b = {w, p};
    for (int i = 16; i >= 0; i--) rx_bits.push_back(b[i]);
`ifdef ESDI_INIT_PARITY_CHECK_EN
    perr = ($countones(b) % 2) == 0;
`else
    perr = 1'b0;
`endif
    exp_resp.push_back({w, perr});
  endtask

  task automatic send(input logic [15:0] w, input int nresp, input logic exp_timeout);
    int n;
    for (int i = 15; i >= 0; i--) exp_tx.push_back(w[i]);
    exp_tx.push_back(($countones(w) % 2) == 0);
    exp_to.push_back(exp_timeout);
    total_hs = 17 + 17 * nresp;
    hs = 0;
    cc = 1'b0;
    n = 0;
    while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("cmd_ready_before_send", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_word = w;
    cmd_resp_words = 3'(nresp);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    int start;
    bit seen;
    start = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #2;
      if (done_cnt != start) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    chk("cmd_ready_after_done", cmd_ready, 1);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", req, 0);
    chk("rst_cdata", cdata, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_perr", resp_parity_err, 0);
    chk("rst_busy", busy, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", cmd_ready, 1);

    send(16'h000E, 0, 1'b0); wait_done(1000);
    send(16'h0001, 0, 1'b0); wait_done(1000);
    send(16'h0000, 0, 1'b0); wait_done(1000);

    add_resp(16'hA5A5, 1'b1);
    add_resp(16'h1234, 1'b0);
    send(16'h8421, 2, 1'b0); wait_done(3000);

    add_resp(16'h0003, 1'b0);
    send(16'h7FFF, 1, 1'b0); wait_done(2000);

    stall_hs = 5;
    send(16'h5555, 0, 1'b1); wait_done(TO + 500);
    chk("timeout_latency_ok", (done_cyc - stall_cyc >= TO) && (done_cyc - stall_cyc <= TO + 2), 1);
    chk("req_low_after_timeout", req, 0);
    stall_hs = -1;
    exp_tx.delete();
    repeat (10) @(posedge clk);
    #1;

    add_resp(16'hBEEF, 1'b0);
    add_resp(16'hCAFE, 1'b0);
    send(16'h0F0F, 2, 1'b0);
    for (int i = 0; i < 2000 && hs < 20; i++) begin @(posedge clk); #2; end
    chk("reached_rx_word1", hs >= 20, 1);
    #3;
    rstn = 1'b0;
    #1;
    chk("mid_rst_req", req, 0);
    chk("mid_rst_cdata", cdata, 0);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_timeout", timeout, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (12) @(posedge clk);
    #1;
    exp_tx.delete();
    exp_resp.delete();
    exp_to.delete();
    rx_bits.delete();
    ack = 1'b0;
    conf = 1'b0;
    hs = 0;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_mid_rst", cmd_ready, 1);

    add_resp(16'h0F0F, 1'b1);
    send(16'h1357, 1, 1'b0); wait_done(2000);

    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("resp_queue_drained", exp_resp.size(), 0);
    chk("done_queue_drained", exp_to.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
